fifo_episode_ctrl: RTL and testbench
====================================

# fifo_episode_ctrl

- Episode controller for one reinforcement-learning run against the FIFO.
- Decodes agent actions into single-cycle FIFO push/pop strobes and masks illegal operations.
- Tracks the chosen goal (FIFO becomes full, or FIFO becomes empty) and reports a signed reward per step.
- Sits between the agent/testbench interface and the FIFO; it is the only driver of the FIFO's push, pop and rst inputs.

## Interface
Parameters:
- DEPTH, 16, FIFO depth; must match the FIFO instance.
- LOG2DEPTH, 4, log2(DEPTH).
- MAX_STEPS, 64, step budget per episode.
- STEP_W, 7, step counter width; must hold MAX_STEPS.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  pulse that begins a new episode; accepted in any state.
- goal_sel  in  1  goal select, sampled with start: 0 = reach full, 1 = reach empty.
- action_valid  in  1  agent action present.
- action  in  2  action code: 00 idle, 01 push, 10 pop, 11 push+pop.
- action_ready  out  1  controller can accept an action.
- fifo_push  out  1  FIFO push strobe.
- fifo_pop  out  1  FIFO pop strobe.
- fifo_rst  out  1  FIFO reset, active-high.
- fifo_full, fifo_empty  in  1  FIFO status flags.
- fifo_full_posedge, fifo_empty_posedge  in  1  FIFO flag rising-edge indicators.
- reward_valid  out  1  one-cycle pulse per completed step.
- reward  out  8  signed reward for the step.
- step_count  out  STEP_W  steps completed in the current episode.
- goal_hit  out  1  goal reached in this episode; sticky until next start.
- done  out  1  episode finished; held until next start.

## Operation
State machine: IDLE, CLR, RUN, EXEC, DONE.
- IDLE: outputs quiet. start moves to CLR.
- CLR (one cycle):
  - fifo_rst = 1.
  - Latch goal_sel.
  - Clear step_count and goal_hit.
  - Go to RUN.
- RUN:
  - action_ready = 1.
  - action_valid accepts the action. The controller registers the push/pop request with masking: push is dropped if fifo_full; pop is dropped if fifo_empty.
  - A dropped request marks the step illegal. Go to EXEC.
- EXEC (one cycle):
  - fifo_push/fifo_pop driven from the masked request.
  - Sample the selected flag posedge (fifo_full_posedge if goal 0, else fifo_empty_posedge) as the hit for this step.
  - Next cycle: reward_valid = 1 and step_count increments.
  - Reward value: +100 on hit; else −10 if illegal; else −1.
  - On hit: set goal_hit and go to DONE. Else if step_count+1 == MAX_STEPS, go to DONE. Else go to RUN.
- DONE: done = 1. Actions are not accepted. start moves to CLR.
- start in RUN or EXEC abandons the episode: go to CLR, with no reward_valid for the abandoned step.
- Idle action (00) is a legal step with reward −1.
- Push+pop on a non-empty, non-full FIFO is legal, and both strobes fire.

## Timing
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - fifo_rst = 1.
  - All other outputs = 0, including step_count, reward, done and goal_hit.
- After reset releases, fifo_rst deasserts on the first edge.
- Reset mid-episode discards the episode; no reward is emitted.
- Action acceptance to strobe: 1 cycle (RUN → EXEC).
- Strobe to reward_valid: reward_valid is high in the cycle after EXEC. That cycle is RUN or DONE, so a new action can be accepted there.
- Step throughput: one action per 2 cycles.
- reward, step_count and goal_hit are registered and update together with reward_valid. reward holds its value until the next step.
- fifo_push and fifo_pop are never high while fifo_rst = 1.

## Structure
- Shared package fifo_rl_pkg holds:
  - action code constants (ACT_IDLE, ACT_PUSH, ACT_POP, ACT_PUSHPOP);
  - reward constants (REW_GOAL = 100, REW_STEP = −1, REW_ILLEGAL = −10);
  - the state enum.
- One sub-module is natural: fifo_action_mask. It is combinational: action plus full/empty flags in, masked push/pop and illegal flag out. Reused by the agent-side model.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles. Require fifo_rst = 1, all other outputs 0, action_ready = 0. On release, require fifo_rst = 0 after 1 cycle.
- Full goal: start with goal_sel = 0, then 16 push actions. Require reward −1 for steps 1–15, then +100 at step 16. Require goal_hit = 1, done = 1, step_count = 16.
- Illegal pop: start, then pop on an empty FIFO. Require fifo_pop to stay 0, reward −10, step_count = 1.
- Empty goal: goal_sel = 1, then push ×3 and pop ×3. Require +100 at step 6 (fifo_empty_posedge), done, goal_hit = 1.
- Timeout: MAX_STEPS = 64 with all idle actions. Require 64 rewards of −1, then done = 1 with goal_hit = 0, and action_ready = 0 afterwards.
- Interrupts, each checked independently:
  - rst_n low after step 5 forces IDLE with no reward_valid.
  - start in DONE restarts via CLR: a fifo_rst pulse, step_count = 0, goal_hit = 0.

Source files
------------

// File: rtl/fifo_rl_pkg.sv
// Shared types and constants for the FIFO RL episode controller.
// Action codes, step rewards, controller state enum, reward helper.
package fifo_rl_pkg;

  localparam logic [1:0] ACT_IDLE    = 2'b00;
  localparam logic [1:0] ACT_PUSH    = 2'b01;
  localparam logic [1:0] ACT_POP     = 2'b10;
  localparam logic [1:0] ACT_PUSHPOP = 2'b11;

  localparam logic signed [7:0] REW_GOAL    = 8'sd100;
  localparam logic signed [7:0] REW_STEP    = -8'sd1;
  localparam logic signed [7:0] REW_ILLEGAL = -8'sd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_EXEC,
    ST_DONE
  } state_t;

  // Goal beats illegality: a step that hits the goal pays
  // the goal reward even if half of it was masked.
  function automatic logic signed [7:0] step_reward(
    input logic hit,
    input logic illegal
  );
    if (hit)
      return REW_GOAL;
    else if (illegal)
      return REW_ILLEGAL;
    else
      return REW_STEP;
  endfunction

endpackage

// File: rtl/fifo_action_mask.sv
// Decodes an agent action and masks ops the FIFO cannot take.
// Ports: i_action, i_full, i_empty in; o_push, o_pop, o_illegal out.
module fifo_action_mask
  import fifo_rl_pkg::*;
(
  input  logic [1:0] i_action,
  input  logic       i_full,
  input  logic       i_empty,
  output logic       o_push,
  output logic       o_pop,
  output logic       o_illegal
);

  logic w_push_req;
  logic w_pop_req;

  always_comb begin
    w_push_req = 1'b0;
    w_pop_req  = 1'b0;
    unique case (i_action)
      ACT_IDLE: ;
      ACT_PUSH: w_push_req = 1'b1;
      ACT_POP:  w_pop_req  = 1'b1;
      ACT_PUSHPOP: begin
        w_push_req = 1'b1;
        w_pop_req  = 1'b1;
      end
    endcase
  end

  assign o_push    = w_push_req & ~i_full;
  assign o_pop     = w_pop_req & ~i_empty;
  assign o_illegal = (w_push_req & i_full)
                   | (w_pop_req & i_empty);

endmodule

// File: rtl/fifo_episode_ctrl.sv
// Episode controller: agent actions -> masked FIFO strobes, rewards.
// Ports: clk/rst_n, start/goal_sel, action handshake, fifo ctrl/flags, reward/status.
module fifo_episode_ctrl
  import fifo_rl_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int LOG2DEPTH = 4,
  parameter int MAX_STEPS = 64,
  parameter int STEP_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              goal_sel,
  input  logic              action_valid,
  input  logic [1:0]        action,
  output logic              action_ready,
  output logic              fifo_push,
  output logic              fifo_pop,
  output logic              fifo_rst,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic              fifo_full_posedge,
  input  logic              fifo_empty_posedge,
  output logic              reward_valid,
  output logic [7:0]        reward,
  output logic [STEP_W-1:0] step_count,
  output logic              goal_hit,
  output logic              done
);

  if (DEPTH != (1 << LOG2DEPTH)) begin : g_bad_depth
    $error("DEPTH must equal 2**LOG2DEPTH");
  end
  if (MAX_STEPS >= (1 << STEP_W)) begin : g_bad_step_w
    $error("STEP_W too narrow for MAX_STEPS");
  end

  localparam logic [STEP_W-1:0] LAST_STEP =
    STEP_W'(MAX_STEPS);

  state_t            r_state;
  logic              r_goal;
  logic              r_illegal;
  logic              r_ready;
  logic              r_push;
  logic              r_pop;
  logic              r_fifo_rst;
  logic              r_rew_vld;
  logic [7:0]        r_reward;
  logic [STEP_W-1:0] r_step;
  logic              r_hit;
  logic              r_done;

  logic              w_push;
  logic              w_pop;
  logic              w_illegal;
  logic              w_hit;
  logic [STEP_W-1:0] w_step_nxt;

  fifo_action_mask u_mask (
    .i_action  (action),
    .i_full    (fifo_full),
    .i_empty   (fifo_empty),
    .o_push    (w_push),
    .o_pop     (w_pop),
    .o_illegal (w_illegal)
  );

  // Posedge indicators flag the edge on which the FIFO
  // flag rises, so they line up with the EXEC strobes.
  assign w_hit = r_goal ? fifo_empty_posedge
                        : fifo_full_posedge;

  assign w_step_nxt = r_step + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_goal     <= 1'b0;
      r_illegal  <= 1'b0;
      r_ready    <= 1'b0;
      r_push     <= 1'b0;
      r_pop      <= 1'b0;
      r_fifo_rst <= 1'b1;
      r_rew_vld  <= 1'b0;
      r_reward   <= '0;
      r_step     <= '0;
      r_hit      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rew_vld <= 1'b0;
      if (start) begin
        // Restart from any state; an in-flight step is
        // dropped without a reward.
        r_state    <= ST_CLR;
        r_fifo_rst <= 1'b1;
        r_goal     <= goal_sel;
        r_step     <= '0;
        r_hit      <= 1'b0;
        r_done     <= 1'b0;
        r_ready    <= 1'b0;
        r_push     <= 1'b0;
        r_pop      <= 1'b0;
        r_illegal  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_fifo_rst <= 1'b0;
          end
          ST_CLR: begin
            r_fifo_rst <= 1'b0;
            r_ready    <= 1'b1;
            r_state    <= ST_RUN;
          end
          ST_RUN: begin
            if (action_valid) begin
              r_push    <= w_push;
              r_pop     <= w_pop;
              r_illegal <= w_illegal;
              r_ready   <= 1'b0;
              r_state   <= ST_EXEC;
            end
          end
          ST_EXEC: begin
            r_push    <= 1'b0;
            r_pop     <= 1'b0;
            r_rew_vld <= 1'b1;
            r_step    <= w_step_nxt;
            r_reward  <= step_reward(w_hit, r_illegal);
            if (w_hit) begin
              r_hit   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else if (w_step_nxt == LAST_STEP) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_ready <= 1'b1;
              r_state <= ST_RUN;
            end
          end
          ST_DONE: ;
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign action_ready = r_ready;
  assign fifo_push    = r_push;
  assign fifo_pop     = r_pop;
  assign fifo_rst     = r_fifo_rst;
  assign reward_valid = r_rew_vld;
  assign reward       = r_reward;
  assign step_count   = r_step;
  assign goal_hit     = r_hit;
  assign done         = r_done;

endmodule

// File: tb/tb_fifo_episode_ctrl.sv
// Scoreboard bench for fifo_episode_ctrl with a behavioural FIFO.
// Stimulus queues expected rewards; a negedge monitor checks them.
module tb_fifo_episode_ctrl;
  import fifo_rl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       goal_sel;
  logic       action_valid;
  logic [1:0] action;
  logic       action_ready;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_rst;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_full_posedge;
  logic       fifo_empty_posedge;
  logic       reward_valid;
  logic [7:0] reward;
  logic [6:0] step_count;
  logic       goal_hit;
  logic       done;

  always #5 clk = ~clk;

  fifo_episode_ctrl #(
    .DEPTH(16), .LOG2DEPTH(4),
    .MAX_STEPS(64), .STEP_W(7)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .goal_sel(goal_sel),
    .action_valid(action_valid), .action(action),
    .action_ready(action_ready),
    .fifo_push(fifo_push), .fifo_pop(fifo_pop),
    .fifo_rst(fifo_rst),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_full_posedge(fifo_full_posedge),
    .fifo_empty_posedge(fifo_empty_posedge),
    .reward_valid(reward_valid), .reward(reward),
    .step_count(step_count), .goal_hit(goal_hit),
    .done(done)
  );

  // Behavioural 16-deep FIFO occupancy model.
  logic [4:0] cnt;
  int pop_strobes;
  always @(posedge clk) begin
    if (fifo_rst)
      cnt <= '0;
    else if (fifo_push && !fifo_pop)
      cnt <= cnt + 5'd1;
    else if (fifo_pop && !fifo_push)
      cnt <= cnt - 5'd1;
    if (fifo_pop) pop_strobes <= pop_strobes + 1;
  end
  assign fifo_full  = (cnt == 5'd16);
  assign fifo_empty = (cnt == 5'd0);
  assign fifo_full_posedge =
    fifo_push && !fifo_pop && !fifo_rst && cnt == 5'd15;
  assign fifo_empty_posedge =
    fifo_pop && !fifo_push && !fifo_rst && cnt == 5'd1;

  typedef struct {
    logic signed [7:0] rew;
    int                step;
    logic              hit;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_step;

  task automatic chk(input string nm,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Monitor: every reward pulse must match the head of the queue.
  always @(negedge clk) begin
    if (reward_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_reward_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("reward", $signed(reward), e.rew);
        chk("step_count", step_count, e.step);
        chk("goal_hit", goal_hit, e.hit);
      end
    end
  end

  task automatic start_ep(input logic g);
    @(negedge clk);
    start = 1'b1;
    goal_sel = g;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("clr_fifo_rst", fifo_rst, 1);
    chk("clr_step_count", step_count, 0);
    chk("clr_goal_hit", goal_hit, 0);
    chk("clr_done", done, 0);
    exp_step = 0;
  endtask

  task automatic do_step(input logic [1:0] a,
                         input logic signed [7:0] rew,
                         input logic hit,
                         input bit expect_rew);
    int n = 0;
    @(negedge clk);
    while (!action_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!action_ready) begin
      chk("action_ready_timeout", 0, 1);
      return;
    end
    action_valid = 1'b1;
    action = a;
    if (expect_rew) begin
      exp_step++;
      sb.push_back('{rew, exp_step, hit});
    end
    @(posedge clk);
    #1 action_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pops0;
    rst_n = 1'b0;
    start = 1'b0;
    goal_sel = 1'b0;
    action_valid = 1'b0;
    action = ACT_IDLE;
    pop_strobes = 0;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_fifo_rst", fifo_rst, 1);
    chk("rst_push", fifo_push, 0);
    chk("rst_pop", fifo_pop, 0);
    chk("rst_ready", action_ready, 0);
    chk("rst_rvalid", reward_valid, 0);
    chk("rst_reward", reward, 0);
    chk("rst_step", step_count, 0);
    chk("rst_goal_hit", goal_hit, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_fifo_rst", fifo_rst, 0);

    // Full goal: 16 pushes, +100 on the 16th
    start_ep(1'b0);
    for (int i = 1; i <= 16; i++)
      do_step(ACT_PUSH, (i == 16) ? 8'sd100 : -8'sd1,
              i == 16, 1'b1);
    repeat (2) @(negedge clk);
    chk("full_done", done, 1);
    chk("full_goal_hit", goal_hit, 1);
    chk("full_step_count", step_count, 16);
    chk("full_ready_off", action_ready, 0);

    // Start in DONE: restart through CLR
    start_ep(1'b0);
    @(negedge clk);
    chk("restart_ready", action_ready, 1);
    chk("restart_fifo_rst_off", fifo_rst, 0);

    // Illegal pop on empty FIFO
    pops0 = pop_strobes;
    do_step(ACT_POP, -8'sd10, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("illegal_pop_strobes", pop_strobes - pops0, 0);
    chk("illegal_step_count", step_count, 1);

    // Empty goal: 3 pushes then 3 pops
    start_ep(1'b1);
    for (int i = 1; i <= 3; i++)
      do_step(ACT_PUSH, -8'sd1, 1'b0, 1'b1);
    do_step(ACT_POP, -8'sd1, 1'b0, 1'b1);
    do_step(ACT_POP, -8'sd1, 1'b0, 1'b1);
    do_step(ACT_POP, 8'sd100, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("empty_done", done, 1);
    chk("empty_goal_hit", goal_hit, 1);
    chk("empty_step_count", step_count, 6);

    // Push+pop on a mid-level FIFO: both strobes, legal
    start_ep(1'b0);
    do_step(ACT_PUSH, -8'sd1, 1'b0, 1'b1);
    pops0 = pop_strobes;
    do_step(ACT_PUSHPOP, -8'sd1, 1'b0, 1'b1);
    @(negedge clk);
    chk("pushpop_push", fifo_push, 1);
    chk("pushpop_pop", fifo_pop, 1);

    // Timeout: 64 idle steps
    start_ep(1'b0);
    for (int i = 1; i <= 64; i++)
      do_step(ACT_IDLE, -8'sd1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("timeout_done", done, 1);
    chk("timeout_goal_hit", goal_hit, 0);
    chk("timeout_step_count", step_count, 64);
    @(negedge clk);
    chk("timeout_ready_off", action_ready, 0);
    chk("timeout_done_held", done, 1);

    // Reset after step 5 discards the episode
    start_ep(1'b0);
    for (int i = 1; i <= 5; i++)
      do_step(ACT_PUSH, -8'sd1, 1'b0, 1'b1);
    do_step(ACT_PUSH, 8'sd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("irq_rst_fifo_rst", fifo_rst, 1);
    chk("irq_rst_step", step_count, 0);
    chk("irq_rst_ready", action_ready, 0);
    chk("irq_rst_reward", reward, 0);
    chk("irq_rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("irq_rel_fifo_rst", fifo_rst, 0);
    repeat (4) @(negedge clk);
    chk("irq_idle_ready", action_ready, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
